// File: rtl/pulse_pacer.sv
// pulse_pacer: queues single-cycle event pulses in a saturating counter and
// re-emits them as one-cycle pulses spaced at least GAP clocks apart, so every
// event survives a toggle-based crossing into a slower clock domain. Events
// that arrive while the queue is full are dropped and flagged in a sticky bit.
module pulse_pacer #(
    parameter int CW  = 4,
    parameter int GAP = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_pulse,
    input  logic          ovfl_clr,
    output logic          out_pulse,
    output logic [CW-1:0] pending,
    output logic          busy,
    output logic          ovfl
);

    localparam int GW = $clog2(GAP);
    localparam logic [GW-1:0] GAP_LOAD = GW'(GAP - 1);
    localparam logic [CW-1:0] PEND_MAX = '1;

    // The state is fully implied by the holdoff and pending counters; naming
    // it keeps the emit decision readable.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HOLDOFF = 2'd1,
        DRAIN   = 2'd2
    } state_t;

    state_t        state;
    logic          emit;
    logic          drop;
    logic [GW-1:0] gap_q, gap_d;
    logic [CW-1:0] pending_q, pending_d;
    logic          ovfl_q, ovfl_d;
    logic          out_pulse_q;

    // Decode the derived state from the counters.
    always_comb begin
        state = IDLE;
        if (gap_q != '0) begin
            state = HOLDOFF;
        end else if (pending_q != '0) begin
            state = DRAIN;
        end
    end

    // Next-state logic: emit decision, holdoff countdown, saturating queue, sticky overflow.
    always_comb begin
        emit      = 1'b0;
        drop      = 1'b0;
        gap_d     = gap_q;
        pending_d = pending_q;
        ovfl_d    = ovfl_q;

        // Outside holdoff, a queued event drains, or a fresh event bypasses the queue.
        emit = (state != HOLDOFF) && ((state == DRAIN) || in_pulse);

        if (emit) begin
            gap_d = GAP_LOAD;
        end else if (gap_q != '0) begin
            gap_d = gap_q - 1'b1;
        end

        // One in and one out in the same cycle leaves the queue untouched,
        // which also covers the bypass case and a full queue that is draining.
        if (in_pulse && !emit) begin
            if (pending_q == PEND_MAX) begin
                drop = 1'b1;
            end else begin
                pending_d = pending_q + 1'b1;
            end
        end else if (emit && !in_pulse) begin
            pending_d = pending_q - 1'b1;
        end

        // A drop in the same cycle as a clear must leave the flag set.
        if (ovfl_clr) begin
            ovfl_d = 1'b0;
        end
        if (drop) begin
            ovfl_d = 1'b1;
        end
    end

    // State registers; reset discards all queued events and any holdoff.
    always_ff @(posedge clk) begin
        if (rst) begin
            gap_q       <= '0;
            pending_q   <= '0;
            ovfl_q      <= 1'b0;
            out_pulse_q <= 1'b0;
        end else begin
            gap_q       <= gap_d;
            pending_q   <= pending_d;
            ovfl_q      <= ovfl_d;
            out_pulse_q <= emit;
        end
    end

    assign out_pulse = out_pulse_q;
    assign pending   = pending_q;
    assign ovfl      = ovfl_q;
    assign busy      = (pending_q != '0) || (gap_q != '0);

endmodule

// File: tb/tb_pulse_pacer.sv
// tb_pulse_pacer: drives two pacers (GAP=8 and GAP=2) with the same randomized
// event stream and compares every cycle against a time-based reference model
// that tracks the queue depth as an integer and the last emission cycle.
module tb_pulse_pacer;

    localparam int CW    = 4;
    localparam int QMAX  = 15;
    localparam int NPH   = 8;
    localparam int PHLEN = 300;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_pulse;
    logic       ovfl_clr;
    logic       out_a, out_b;
    logic [3:0] pend_a, pend_b;
    logic       busy_a, busy_b;
    logic       ovfl_a, ovfl_b;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pulse_pacer #(.CW(CW), .GAP(8)) dut_a (
        .clk(clk), .rst(rst), .in_pulse(in_pulse), .ovfl_clr(ovfl_clr),
        .out_pulse(out_a), .pending(pend_a), .busy(busy_a), .ovfl(ovfl_a)
    );

    pulse_pacer #(.CW(CW), .GAP(2)) dut_b (
        .clk(clk), .rst(rst), .in_pulse(in_pulse), .ovfl_clr(ovfl_clr),
        .out_pulse(out_b), .pending(pend_b), .busy(busy_b), .ovfl(ovfl_b)
    );

    // Reference model state, one slot per DUT.
    int gapv[2]    = '{8, 2};
    int q[2];
    int last_e[2];
    int m_ovfl[2];
    int m_out[2];
    int m_busy[2];
    int last_obs[2];
    int drops = 0;
    int emits = 0;

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        if (obs != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            q[i]        = 0;
            last_e[i]   = -1000;
            m_ovfl[i]   = 0;
            m_out[i]    = 0;
            m_busy[i]   = 0;
            last_obs[i] = -1000;
        end
    endtask

    // Advance the model across the clock edge numbered k.
    task automatic model_step(input int k, input int r, input int inp, input int clr);
        int e, n, d;
        if (r != 0) begin
            model_reset();
            return;
        end
        for (int i = 0; i < 2; i++) begin
            e = ((k - last_e[i] >= gapv[i]) && (q[i] > 0 || inp != 0)) ? 1 : 0;
            n = q[i] + inp - e;
            d = (n > QMAX) ? 1 : 0;
            if (d != 0) n = QMAX;
            q[i] = n;
            if (e != 0) last_e[i] = k;
            m_out[i] = e;
            if (d != 0) m_ovfl[i] = 1;
            else if (clr != 0) m_ovfl[i] = 0;
            m_busy[i] = (q[i] > 0 || (k - last_e[i] < gapv[i] - 1)) ? 1 : 0;
            drops += d;
            emits += e;
        end
    endtask

    task automatic check_all(input int k);
        int o[2], p[2], b[2], f[2];
        o = '{int'(out_a), int'(out_b)};
        p = '{int'(pend_a), int'(pend_b)};
        b = '{int'(busy_a), int'(busy_b)};
        f = '{int'(ovfl_a), int'(ovfl_b)};
        for (int i = 0; i < 2; i++) begin
            check($sformatf("out_pulse[g%0d]", gapv[i]), o[i], m_out[i]);
            check($sformatf("pending[g%0d]", gapv[i]), p[i], q[i]);
            check($sformatf("busy[g%0d]", gapv[i]), b[i], m_busy[i]);
            check($sformatf("ovfl[g%0d]", gapv[i]), f[i], m_ovfl[i]);
            if (o[i] != 0) begin
                check($sformatf("spacing_ok[g%0d]", gapv[i]),
                      (k - last_obs[i] >= gapv[i]) ? 1 : 0, 1);
                last_obs[i] = k;
            end
        end
    endtask

    int dens[NPH] = '{10, 100, 50, 0, 90, 25, 100, 5};

    initial begin
        int k, r, inp, clr;
        rst      = 1'b1;
        in_pulse = 1'b1;
        ovfl_clr = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        check_all(0);
        rst      = 1'b0;
        in_pulse = 1'b0;
        ovfl_clr = 1'b0;
        k = 1;
        for (int ph = 0; ph < NPH; ph++) begin
            for (int c = 0; c < PHLEN; c++) begin
                r   = ($urandom_range(0, 249) == 0) ? 1 : 0;
                inp = ($urandom_range(1, 100) <= dens[ph]) ? 1 : 0;
                clr = ($urandom_range(0, 39) == 0) ? 1 : 0;
                rst      = r[0];
                in_pulse = inp[0];
                ovfl_clr = clr[0];
                model_step(k, r, inp, clr);
                @(negedge clk);
                check_all(k);
                k++;
            end
            $display("phase %0d density=%0d%% checks=%0d bad=%0d emits=%0d drops=%0d",
                     ph, dens[ph], total, bad, emits, drops);
        end
        // Mid-drain reset with a simultaneous event must empty everything.
        rst = 1'b0; ovfl_clr = 1'b0; in_pulse = 1'b1;
        for (int c = 0; c < 40; c++) begin
            model_step(k, 0, 1, 0);
            @(negedge clk);
            check_all(k);
            k++;
        end
        rst = 1'b1;
        model_step(k, 1, 1, 0);
        @(negedge clk);
        check_all(k);
        k++;
        rst = 1'b0; in_pulse = 1'b0;
        for (int c = 0; c < 20; c++) begin
            model_step(k, 0, 0, 0);
            @(negedge clk);
            check_all(k);
            k++;
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
